// File: rtl/seq_divider_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;
  localparam int DIV_WIDTH_DEFAULT = 16;

  typedef enum logic {
    DIV_IDLE,
    DIV_CALC
  } div_state_t;

  function automatic int div_cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] numer;
  logic [WIDTH-1:0] denom;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remain;
  logic             div_by_zero;

  modport master (
    output start, numer, denom,
    input  busy, done, quotient, remain, div_by_zero
  );

  modport slave (
    input  start, numer, denom,
    output busy, done, quotient, remain, div_by_zero
  );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring division iteration, purely combinational.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] acc_next,
  output logic             q_bit
);
  logic [WIDTH:0] trial;

  // Compare at WIDTH+1 bits; after subtracting, the result is < d
  assign trial    = {acc, q_msb};
  assign q_bit    = (trial >= {1'b0, d});
  assign acc_next = q_bit ? (trial[WIDTH-1:0] - d)
                          : trial[WIDTH-1:0];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  seq_divider_if.slave bus
);
  localparam int CW = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] acc_n;
  logic             q_bit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .q_msb   (q[WIDTH-1]),
    .d       (d),
    .acc_next(acc_n),
    .q_bit   (q_bit)
  );

  assign bus.busy = (state == DIV_CALC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= DIV_IDLE;
      count           <= '0;
      acc             <= '0;
      q               <= '0;
      d               <= '0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remain      <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        DIV_IDLE: begin
          if (bus.start) begin
            q     <= bus.numer;
            acc   <= '0;
            d     <= bus.denom;
            count <= '0;
            state <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          acc   <= acc_n;
          q     <= {q[WIDTH-2:0], q_bit};
          count <= count + 1'b1;
          // Final iteration publishes the result directly
          if (count == LAST) begin
            bus.quotient    <= {q[WIDTH-2:0], q_bit};
            bus.remain      <= acc_n;
            bus.div_by_zero <= (d == '0);
            bus.done        <= 1'b1;
            state           <= DIV_IDLE;
          end
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider core that sits directly downstream of the bus-mapped divider register block.
- Consumes the numerator/denominator operand registers and produces registered quotient and remainder for the read-back mux.
- Produces one quotient bit per clock, using a start/busy/done handshake in place of a free-running combinational core.

Parameters:
- WIDTH, 16, operand/result width in bits (>= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- start  input  1  request; sampled only in IDLE; one-cycle pulse expected, level tolerated.
- numer  input  WIDTH  unsigned dividend; sampled on the accepting edge.
- denom  input  WIDTH  unsigned divisor; sampled on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when quotient/remain update.
- quotient  output  WIDTH  registered result; held until next done.
- remain  output  WIDTH  registered remainder; held until next done.
- div_by_zero  output  1  registered flag for the last completed operation; updates with done.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, quotient=0, remain=0, div_by_zero=0; internal shift/count registers cleared.
- Reset mid-operation aborts the division with no done pulse. After reset releases, the block sits in IDLE.
- States: IDLE, CALC.
  - IDLE, start=1 at edge E0: latch numer into the quotient shift register; remainder accumulator = 0; latch denom; count = 0; go to CALC; busy=1.
  - IDLE, start=0: stay; done=0.
  - CALC, each edge:
    - acc' = {acc[WIDTH-2:0], q[WIDTH-1]}; q shifts left.
    - If acc' >= d: acc' -= d and the new q LSB = 1; else the LSB = 0.
    - Compare and subtract at WIDTH+1 bits so no carry is lost.
    - count increments.
  - CALC, edge WIDTH (E16 for the default): load quotient/remain outputs; div_by_zero = (latched denom == 0); done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is high in the cycle after edge E0+WIDTH, i.e. WIDTH clocks after the start edge. busy is high for exactly WIDTH cycles.
- start while busy: ignored, with no queuing and no effect on the in-flight operation. Operand changes while busy are also ignored.
- Back-to-back: start asserted in the same cycle as done is accepted (state is already IDLE). That gives throughput of one operation every WIDTH+1 cycles.
- Divide by zero: same latency, no special path. Result is quotient = all ones and remain = numer (the natural restoring result), with div_by_zero=1.
- numer < denom: quotient=0, remain=numer.
- Outputs quotient/remain/div_by_zero change only on the done edge or on reset.

Decomposition:
- Package div_pkg holds:
  - localparam DIV_WIDTH_DEFAULT = 16;
  - typedef enum logic {DIV_IDLE, DIV_CALC} div_state_t;
  - count width function/constant $clog2(WIDTH)+1.
- Optional sub-module div_step: purely combinational, one restoring iteration. Inputs are acc, q_msb and d; outputs are next acc and the quotient bit. It keeps the FSM file focused on sequencing.
- FSM, counters and output registers live in seq_divider.

Test Plan:
- Reset=0 asserted asynchronously between edges -> all outputs 0 immediately; release; numer=100, denom=7, start pulse -> busy for 16 cycles; done pulse 16 clocks after start edge; quotient=14, remain=2, div_by_zero=0.
- numer=16'hFFFF, denom=1 -> quotient=16'hFFFF, remain=0. Then numer=5, denom=10 -> quotient=0, remain=5.
- numer=16'h1234, denom=0 -> after 16 cycles quotient=16'hFFFF, remain=16'h1234, div_by_zero=1. Next op 9/3 clears the flag: quotient=3, remain=0.
- Start numer=1000/denom=3; at cycle 5 pulse start with numer=50/denom=5 -> ignored; result 333 r1; no second done.
- Start an operation; drive reset=0 at cycle 8 -> busy=0, no done, outputs 0. After release, 65535/256 -> quotient=255, remain=255.
- Back-to-back: start 200/9, then start 7/7 in the done cycle -> done pulses exactly 17 cycles apart; results 22 r2, then 1 r0; quotient holds 22 until the second done.
